// File: rtl/video_capture_if.sv
// video_capture_if: write port into the LE18-format graphics RAM.
//   wr_en   - one-cycle write strobe
//   wr_addr - {y[7:0], x[5:0]}, y 0..191, x 0..63
//   wr_data - 6 pixels, bit 0 is the leftmost pixel
// master: the capture block that drives the port.
// slave:  the RAM side that receives the writes.
interface video_capture_if;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [5:0]  wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/video_capture.sv
// video_capture: samples a 1-bit monochrome video stream with separate
// HSYNC/VSYNC and rebuilds a 384x192 bitmap as 64x192 words of 6 pixels.
// The words are written into the graphics RAM through an LE18 port.
//
// Ports:
//   clk, srst        - system clock; synchronous active-high reset
//   capture_en       - capture request, looked at only on a VSYNC fall
//   VID_IN           - async video input, 1 = lit
//   HSYNC_IN         - async horizontal sync, active-high
//   VSYNC_IN         - async vertical sync, active-high
//   wr               - RAM write port (video_capture_if.master)
//   frame_done       - one-cycle pulse after word (191,63) has been written
//   locked           - a whole frame was captured and VSYNC has not timed out
//   line_short       - sticky flag: a line ended before all 64 words were written
//   genlock          - one-cycle frame-sync pulse for the VGA timing generator
//
// Optional build macro VIDEO_CAPTURE_GENLOCK_EN:
//   defined   - genlock pulses on every VSYNC fall seen while locked
//   undefined - genlock is tied to 0
//
// Parameters: PIX_DIV (>=2) is clk cycles per source pixel. H_START (>=2) is
// clk cycles from an HSYNC fall to the first sample. V_START is the number
// of HSYNC falls before line 0. V_TIMEOUT is the number of lines without
// VSYNC before lock is dropped.
module video_capture #(
    parameter int PIX_DIV   = 6,
    parameter int H_START   = 40,
    parameter int V_START   = 8,
    parameter int V_TIMEOUT = 400
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            capture_en,
    input  logic            VID_IN,
    input  logic            HSYNC_IN,
    input  logic            VSYNC_IN,
    video_capture_if.master wr,
    output logic            frame_done,
    output logic            locked,
    output logic            line_short,
    output logic            genlock
);
    localparam int DIV_W = $clog2(PIX_DIV);
    localparam int HC_W  = $clog2(H_START);
    localparam int LC_W  = $clog2(V_TIMEOUT + 1);
    localparam logic [7:0] Y_LAST = 8'd191;

    typedef enum logic [2:0] {IDLE, VBLANK, HDELAY, ACTIVE, LINEEND} state_t;
    state_t state;

    // Bit 0 is VID, bit 1 is HSYNC, bit 2 is VSYNC. Only the syncs need edge detection.
    logic [2:0] sync1, sync2;
    logic [1:0] sync_d;
    logic       vid, hs_fall, vs_fall;

    assign vid     = sync2[0];
    assign hs_fall = sync_d[0] & ~sync2[1];
    assign vs_fall = sync_d[1] & ~sync2[2];

    logic [7:0]       y;
    logic [5:0]       x;
    logic [2:0]       bit_idx;
    logic [DIV_W-1:0] div;
    logic [HC_W-1:0]  hcnt;
    logic [4:0]       shift;      // the 6th pixel goes straight to wr_data
    logic [LC_W-1:0]  line_cnt;
    logic             word_done, line_full;

    assign word_done = (state == ACTIVE) && (div == '0) && (bit_idx == 3'd5);
    assign line_full = word_done && (x == 6'd63);

    always_ff @(posedge clk) begin
        if (srst) begin
            sync1      <= '0;
            sync2      <= '0;
            sync_d     <= '0;
            state      <= IDLE;
            y          <= '0;
            x          <= '0;
            bit_idx    <= '0;
            div        <= '0;
            hcnt       <= '0;
            shift      <= '0;
            line_cnt   <= '0;
            wr.wr_en   <= 1'b0;
            wr.wr_addr <= '0;
            wr.wr_data <= '0;
            frame_done <= 1'b0;
            locked     <= 1'b0;
            line_short <= 1'b0;
        end else begin
            sync1      <= {VSYNC_IN, HSYNC_IN, VID_IN};
            sync2      <= sync1;
            sync_d     <= sync2[2:1];
            frame_done <= 1'b0;

            // A word that completes now is always written, even when a sync
            // fall arrives in the same cycle.
            wr.wr_en <= word_done;
            if (word_done) begin
                wr.wr_addr <= {y, x};
                wr.wr_data <= {vid, shift};
            end

            // Line count since the last VSYNC fall; it saturates, and lock is
            // dropped on the fall that makes it reach the limit.
            if (vs_fall) begin
                line_cnt <= '0;
            end else if (hs_fall && line_cnt != LC_W'(V_TIMEOUT)) begin
                line_cnt <= line_cnt + LC_W'(1);
                if (line_cnt == LC_W'(V_TIMEOUT - 1))
                    locked <= 1'b0;
            end

            if (vs_fall) begin
                // A VSYNC fall wins over everything else and restarts the frame.
                state <= capture_en ? VBLANK : IDLE;
                if (capture_en)
                    line_short <= 1'b0;
            end else if (hs_fall && (state == HDELAY || state == ACTIVE || state == LINEEND)) begin
                // The line is over, either normally or early. An early end
                // drops the partial word.
                if (state != LINEEND && !line_full)
                    line_short <= 1'b1;
                x <= '0;
                if (y == Y_LAST) begin
                    frame_done <= 1'b1;
                    locked     <= 1'b1;
                    state      <= IDLE;
                end else begin
                    y     <= y + 8'd1;
                    hcnt  <= HC_W'(1);   // the fall cycle itself counts toward H_START
                    state <= HDELAY;
                end
            end else begin
                case (state)
                    VBLANK: begin
                        if (hs_fall && line_cnt == LC_W'(V_START - 1)) begin
                            y     <= '0;
                            hcnt  <= HC_W'(1);
                            state <= HDELAY;
                        end
                    end
                    HDELAY: begin
                        if (hcnt == HC_W'(H_START - 1)) begin
                            x       <= '0;
                            bit_idx <= '0;
                            div     <= '0;
                            state   <= ACTIVE;
                        end else begin
                            hcnt <= hcnt + HC_W'(1);
                        end
                    end
                    ACTIVE: begin
                        div <= (div == DIV_W'(PIX_DIV - 1)) ? '0 : div + DIV_W'(1);
                        if (div == '0) begin
                            if (bit_idx == 3'd5) begin
                                bit_idx <= '0;
                                x       <= x + 6'd1;
                                if (x == 6'd63)
                                    state <= LINEEND;
                            end else begin
                                shift[bit_idx] <= vid;
                                bit_idx        <= bit_idx + 3'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef VIDEO_CAPTURE_GENLOCK_EN
    always_ff @(posedge clk) begin
        if (srst)
            genlock <= 1'b0;
        else
            genlock <= vs_fall & locked;
    end
`else
    assign genlock = 1'b0;
`endif

endmodule

// File: tb/tb_video_capture.sv
// tb_video_capture: directed bench for video_capture using default timing
// parameters (PIX_DIV=6, H_START=40, V_START=8, V_TIMEOUT=400). Most lines
// are cut short so that whole frames stay cheap. The video pattern 101100
// repeats, so every captured word reads 6'b001101.
module tb_video_capture;
    localparam int PIX_DIV = 6;
    localparam int H_START = 40;
    localparam int L_FULL  = 2360;   // fall-to-fall length that fits all 64 words
`ifdef VIDEO_CAPTURE_GENLOCK_EN
    localparam logic GL_EXP = 1'b1;
`else
    localparam logic GL_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic srst, capture_en, VID_IN, HSYNC_IN, VSYNC_IN;
    logic frame_done, locked, line_short, genlock;
    logic [5:0] pat_r = 6'b001101;

    video_capture_if wr_bus ();

    video_capture #(.PIX_DIV(PIX_DIV), .H_START(H_START), .V_START(8), .V_TIMEOUT(400)) dut (
        .clk        (clk),
        .srst       (srst),
        .capture_en (capture_en),
        .VID_IN     (VID_IN),
        .HSYNC_IN   (HSYNC_IN),
        .VSYNC_IN   (VSYNC_IN),
        .wr         (wr_bus),
        .frame_done (frame_done),
        .locked     (locked),
        .line_short (line_short),
        .genlock    (genlock)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int fd_cnt = 0;
    logic wr_prev = 1'b0;
    logic [13:0] exp_a;
    logic [13:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor, which checks each write against the expected queue.
    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (wr_bus.wr_en) begin
            wr_cnt++;
            n_cmp++;
            assert (!wr_prev) else begin
                n_err++;
                $error("FAIL wr_back2back: wr_en high two cycles at addr %h, expected gap", wr_bus.wr_addr);
            end
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL wr_unexpected: write at addr %h, expected none", wr_bus.wr_addr);
            end
            if (exp_q.size() != 0) begin
                exp_a = exp_q.pop_front();
                n_cmp++;
                assert (wr_bus.wr_addr === exp_a) else begin
                    n_err++;
                    $error("FAIL wr_addr: got %h expected %h", wr_bus.wr_addr, exp_a);
                end
                n_cmp++;
                assert (wr_bus.wr_data === pat_r) else begin
                    n_err++;
                    $error("FAIL wr_data: got %b expected %b", wr_bus.wr_data, pat_r);
                end
            end
        end
        wr_prev = wr_bus.wr_en;
    end

    task automatic push_line(input int yy, input int n);
        logic [7:0] y8;
        logic [5:0] x6;
        for (int i = 0; i < n; i++) begin
            y8 = yy[7:0];
            x6 = i[5:0];
            exp_q.push_back({y8, x6});
        end
    endtask

    // The task runs len cycles and ends with an HSYNC fall. Video is phased
    // so that pixel p sits centred on its sample point when the task starts
    // on a fall.
    task automatic hs_run(input int len);
        int p;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            p = k + 3 - H_START;
            if (p >= 0) VID_IN = pat_r[(p / PIX_DIV) % 6];
            else        VID_IN = 1'b0;
            if (k == len - 2) HSYNC_IN = 1'b1;
            if (k == len)     HSYNC_IN = 1'b0;
        end
    endtask

    task automatic vs_pulse();
        VSYNC_IN = 1'b1;
        repeat (2) @(negedge clk);
        VSYNC_IN = 1'b0;
    endtask

    initial begin
        srst = 1'b1; capture_en = 1'b0; VID_IN = 1'b0; HSYNC_IN = 1'b0; VSYNC_IN = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", wr_bus.wr_en, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_locked", locked, 0);
        chk("rst_line_short", line_short, 0);
        chk("rst_genlock", genlock, 0);
        srst = 1'b0;

        // Frame 1: line 0 and line 191 are full, line 5 is cut after 40 words,
        // line 6 after 1 word, and the other lines are cut in HDELAY.
        capture_en = 1'b1;
        vs_pulse();
        repeat (8) hs_run(12);
        push_line(0, 64);   hs_run(L_FULL);
        repeat (4) hs_run(12);
        push_line(5, 40);   hs_run(1490);
        push_line(6, 1);    hs_run(90);
        repeat (184) hs_run(12);
        push_line(191, 64); hs_run(L_FULL);
        repeat (2) @(negedge clk);
        chk("fd_early", frame_done, 0);
        chk("locked_early", locked, 0);
        @(negedge clk);
        chk("fd_pulse", frame_done, 1);
        chk("locked_rise", locked, 1);
        @(negedge clk);
        chk("fd_one_cycle", frame_done, 0);
        chk("line_short_set", line_short, 1);
        chk("f1_missing_writes", exp_q.size(), 0);
        chk("f1_wr_cnt", wr_cnt, 169);

        // Frame 2: VSYNC arrives at line 101, and the next frame restarts at {0,0}.
        vs_pulse();
        repeat (3) @(negedge clk);
        chk("line_short_clr", line_short, 0);
        repeat (108) hs_run(12);
        push_line(100, 1); hs_run(90);
        vs_pulse();
        repeat (8) hs_run(12);
        push_line(0, 1); hs_run(90);
        repeat (4) @(negedge clk);
        chk("abort_no_fd", fd_cnt, 1);
        chk("abort_missing_writes", exp_q.size(), 0);
        chk("abort_locked", locked, 1);

        // The genlock pulse comes 3 cycles after the VSYNC pin fall. After
        // that, the VSYNC timeout is tested.
        capture_en = 1'b0;
        vs_pulse();
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            chk("genlock", genlock, (j == 3) ? GL_EXP : 1'b0);
        end
        repeat (399) hs_run(6);
        repeat (3) @(negedge clk);
        chk("locked_399", locked, 1);
        hs_run(6);
        repeat (3) @(negedge clk);
        chk("locked_400", locked, 0);

        // Capture gating: a frame with capture_en=0 gives no writes, and so
        // does raising capture_en in the middle of that frame.
        vs_pulse();
        repeat (8) hs_run(12);
        hs_run(L_FULL);
        capture_en = 1'b1;
        repeat (3) hs_run(90);
        chk("gate_wr_cnt", wr_cnt, 171);
        vs_pulse();
        repeat (8) hs_run(12);
        push_line(0, 1); hs_run(90);

        // srst is asserted just before the first write of line 1.
        repeat (72) @(negedge clk);
        chk("pre_rst_wr_cnt", wr_cnt, 172);
        chk("pre_rst_line_short", line_short, 1);
        srst = 1'b1;
        @(negedge clk);
        chk("mid_rst_wr_en", wr_bus.wr_en, 0);
        chk("mid_rst_line_short", line_short, 0);
        srst = 1'b0;
        hs_run(L_FULL);
        chk("post_rst_wr_cnt", wr_cnt, 172);
        chk("final_missing_writes", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/video_capture.md
# video_capture

Capture-side counterpart of the VGA/LE18 output path: samples an external 1-bit monochrome video stream with separate HSYNC/VSYNC and reconstructs a 384x192 bitmap as 64x192 words of 6 pixels. It writes into an LE18-format port of the graphics RAM using the same `{y[7:0], x[5:0]}` addressing, with bit 0 as the leftmost pixel. It also drives the `genlock` input of the VGA timing generator and reports lock and overrun status to the Z80 register file.

## Interface
- `PIX_DIV`, 6: clk cycles per source pixel (≥2).
- `H_START`, 40: clk cycles from detected HSYNC fall to the first pixel sample.
- `V_START`, 8: HSYNC falls after detected VSYNC fall before active line 0.
- `V_TIMEOUT`, 400: lines without VSYNC before lock is dropped.
- `clk` in 1: system clock.
- `srst` in 1: reset, synchronous, active-high.
- `capture_en` in 1: capture request; sampled only at VSYNC fall.
- `VID_IN` in 1: async video, 1 = lit.
- `HSYNC_IN` in 1: async, active-high.
- `VSYNC_IN` in 1: async, active-high.
- `wr_en` out 1: one-cycle RAM write strobe.
- `wr_addr` out 14: `{y, x}`, y 0–191, x 0–63.
- `wr_data` out 6: pixels; bit 0 is leftmost.
- `frame_done` out 1: one-cycle pulse after word (191,63) is written.
- `locked` out 1: a complete frame has been captured and VSYNC has not timed out.
- `line_short` out 1: sticky; cleared by srst or at the `capture_en` sample.
- `genlock` out 1: one-cycle frame-sync pulse (see Configuration).

## Operation
- **Synchronization:** all three async inputs pass through 2-flop synchronizers followed by one edge-detect register. An edge is therefore seen 3 cycles after the pin changes. The rising edge of HSYNC/VSYNC is the "fall" in negative terms: a *sync fall* means the synced sync signal goes 1→0, i.e. the end of the sync pulse.
- **State machine:**
  - **IDLE:** wait for a VSYNC fall.
    - If `capture_en`=1 → VBLANK, with `line_cnt` = 0 and `line_short` cleared.
    - Otherwise stay in IDLE.
  - **VBLANK:** count HSYNC falls. When the count reaches `V_START`, go to HDELAY with y = 0.
  - **HDELAY:** count `H_START` clk cycles from the HSYNC fall, then go to ACTIVE with x = 0, bit = 0 and the divider cleared.
  - **ACTIVE:**
    - Sample synced VID when the divider equals 0, into `shift[bit]`.
    - The divider wraps at `PIX_DIV`−1.
    - After the 6th sample of a word, the next cycle asserts `wr_en` with `wr_addr={y,x}` and `wr_data=shift`, then increments x.
    - After x = 63 is written, go to LINEEND.
  - **LINEEND:** wait for an HSYNC fall.
    - If y = 191 → pulse `frame_done`, set `locked`, go to IDLE.
    - Otherwise increment y and go to HDELAY.
- **Early HSYNC fall in HDELAY or ACTIVE:**
  - Set `line_short`.
  - Discard the partial word (no write).
  - Advance y as in LINEEND; x restarts at 0 on the new line.
- **VSYNC fall in any state other than IDLE:** abort the frame with no `frame_done` and re-enter VBLANK, or IDLE if `capture_en`=0. Writes already issued stand.
- **Timeout:** `line_cnt` counts HSYNC falls since the last VSYNC fall. Reaching `V_TIMEOUT` clears `locked`; the counter saturates.
- **Simultaneous events:** a VSYNC fall in the same cycle as an HSYNC fall takes priority. A write completing in the same cycle as an HSYNC fall is issued before the abort.

## Timing
- **Reset values:** all outputs 0, state IDLE, counters 0, synchronizers 0.
- **Write cadence:** one write every 6·`PIX_DIV` cycles. `wr_en` is never asserted on two consecutive cycles.
- **First sample:** taken `H_START`+3 cycles after the HSYNC pin falls.
- **`frame_done`:** asserted the cycle after the LINEEND HSYNC fall that follows y = 191. `locked` rises in the same cycle.
- **Reset mid-frame:** srst returns the block to IDLE on the next edge. Any partial word is lost and `wr_en` is 0 in the cycle after srst.

## Configuration
- **`VIDEO_CAPTURE_GENLOCK_EN` defined:** `genlock` pulses for 1 cycle at every detected VSYNC fall while `locked`=1. It therefore resets the VGA counters in phase with the source frame.
- **Not defined:** `genlock` is tied 0 and the VGA output free-runs. All capture behaviour is unchanged.

## Test plan
- **Nominal frame:** srst, `capture_en`=1, synthetic frame with `PIX_DIV`=6, `V_START`=8 and source pixel pattern 101100 repeating → 12288 writes with `wr_data`=6'b001101. Addresses run 0x0000..0x2FFF in order, then one `frame_done`, and `locked`=1.
- **Short line:** HSYNC fall after 40 words on line 5 → `line_short`=1. No write at (5,40). The next write is `{8'd6, 6'd0}`.
- **VSYNC mid-frame:** VSYNC pulse at line 100 → no `frame_done`. The following frame starts again at `{0,0}` after 8 lines.
- **Timeout:** after a locked frame, hold VSYNC low and emit 400 HSYNC pulses → `locked` falls on the 400th fall.
- **Capture gating:** `capture_en`=0 at a VSYNC fall → no `wr_en` that frame. Raising `capture_en` mid-frame → capture starts only at the next VSYNC fall.
- **Genlock (macro on):** with `locked`=1, a VSYNC pin fall → `genlock` high for exactly 1 cycle, 3 cycles later. With the macro off, `genlock` stays 0.
